entry_capture: RTL and testbench

ENTRY_CAPTURE -- requirements
Module: entry_capture

---
 rtl/combo_lock_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/entry_capture.sv | 134 +++++++++++++
 tb/tb_entry_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module : combo_lock_pkg
// Brief  : Shared types and widths for the combination-lock entry path.
// Rev    : 1.0  initial release
// ============================================================================
package combo_lock_pkg;

    localparam int CODE_W    = 16;
    localparam int ATTEMPT_W = 2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESENT     = 3'd2,
        DEB_RELEASE = 3'd3,
        LOCKED      = 3'd4
    } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : 2-flop synchronizer plus stability counter steered by the entry FSM.
// Rev    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    input  logic track_press,
    input  logic track_release,
    output logic press_pulse,
    output logic release_done,
    output logic level,
    output logic armed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_press = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       r_sync;
    logic [1:0]       r_warm;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_btn_s;
    logic             w_counting;

    assign w_btn_s    = r_sync[1];
    assign w_counting = (track_press & w_btn_s) | (track_release & ~w_btn_s);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync  <= 2'b00;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            r_warm <= {r_warm[0], 1'b1};
            // Arm only once the synchronizer holds real samples showing a release.
            if (r_warm[1] && !w_btn_s) begin
                r_armed <= 1'b1;
            end
            if (!w_counting) begin
                r_cnt <= '0;
            end else if (r_cnt != c_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // The IDLE cycle that spotted the press already counts as one stable cycle.
    assign press_pulse  = track_press & w_btn_s & (r_cnt == c_press);
    assign release_done = track_release & ~w_btn_s & (r_cnt == c_last);
    assign level        = w_btn_s;
    assign armed        = r_armed;

endmodule
`default_nettype wire

// File: rtl/entry_capture.sv
`default_nettype none
// ============================================================================
// Module : entry_capture
// Brief  : Debounced code capture with valid/ready handoff and failed-attempt lockout.
// Rev    : 1.0  initial release
// ============================================================================
module entry_capture
    import combo_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 100000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_raw,
    input  logic [CODE_W-1:0]    sw,
    input  logic                 code_ready,
    input  logic                 attempt_fail,
    input  logic                 attempt_ok,
    output logic [CODE_W-1:0]    code_out,
    output logic                 code_valid,
    output logic [ATTEMPT_W-1:0] attempts,
    output logic                 lockout
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0]    c_lock_load    = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [ATTEMPT_W-1:0] c_max_attempts = ATTEMPT_W'(MAX_ATTEMPTS);

    entry_state_t         r_state;
    entry_state_t         w_state_next;
    logic [CODE_W-1:0]    r_code;
    logic [ATTEMPT_W-1:0] r_attempts;
    logic [LOCK_W-1:0]    r_lock_cnt;
    logic                 w_capture;
    logic                 w_lock_enter;
    logic                 w_lock_exit;
    logic                 w_press_pulse;
    logic                 w_release_done;
    logic                 w_level;
    logic                 w_armed;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .track_press   (r_state == DEB_PRESS),
        .track_release (r_state == DEB_RELEASE),
        .press_pulse   (w_press_pulse),
        .release_done  (w_release_done),
        .level         (w_level),
        .armed         (w_armed)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_level && w_armed) begin
                    w_state_next = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!w_level) begin
                    w_state_next = IDLE;
                end else if (w_press_pulse) begin
                    w_state_next = PRESENT;
                    w_capture    = 1'b1;
                end
            end
            PRESENT: begin
                if (code_ready) begin
                    w_state_next = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (w_release_done) begin
                    w_state_next = IDLE;
                end
            end
            LOCKED: begin
                // Leave via release-debounce so a button held through lockout is ignored.
                if (r_lock_cnt == '0) begin
                    w_state_next = DEB_RELEASE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (r_state != LOCKED && r_attempts == c_max_attempts) begin
            w_state_next = LOCKED;
            w_capture    = 1'b0;
        end
    end

    assign w_lock_enter = (w_state_next == LOCKED) && (r_state != LOCKED);
    assign w_lock_exit  = (r_state == LOCKED) && (r_lock_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_code     <= '0;
            r_attempts <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_code <= sw;
            end
            if (w_lock_exit || attempt_ok) begin
                r_attempts <= '0;
            end else if (attempt_fail && r_attempts != c_max_attempts) begin
                r_attempts <= r_attempts + 1'b1;
            end
            if (w_lock_enter) begin
                r_lock_cnt <= c_lock_load;
            end else if (r_state == LOCKED && r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - 1'b1;
            end
        end
    end

    assign code_out   = r_code;
    assign code_valid = (r_state == PRESENT);
    assign attempts   = r_attempts;
    assign lockout    = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_entry_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_entry_capture
// Brief  : Directed scoreboard bench for entry_capture (DEBOUNCE=4, LOCKOUT=20).
// Rev    : 1.0  initial release
// ============================================================================
module tb_entry_capture;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic        btn_raw      = 1'b0;
    logic [15:0] sw           = 16'h0000;
    logic        code_ready   = 1'b0;
    logic        attempt_fail = 1'b0;
    logic        attempt_ok   = 1'b0;
    logic [15:0] code_out;
    logic        code_valid;
    logic [1:0]  attempts;
    logic        lockout;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          n_hs        = 0;
    int          n_valid     = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_code;
    logic        prev_valid  = 1'b0;
    logic [15:0] prev_code   = 16'h0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    entry_capture #(
        .DEBOUNCE_CYCLES (4),
        .MAX_ATTEMPTS    (3),
        .LOCKOUT_CYCLES  (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .sw           (sw),
        .code_ready   (code_ready),
        .attempt_fail (attempt_fail),
        .attempt_ok   (attempt_ok),
        .code_out     (code_out),
        .code_valid   (code_valid),
        .attempts     (attempts),
        .lockout      (lockout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int lat);
        int t0;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (code_valid) begin
                lat = cyc - t0;
                return;
            end
            tick(1);
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: got no code_valid within 40 cycles, expected a capture", name);
    endtask

    task automatic pulse(input logic f, input logic o);
        attempt_fail = f;
        attempt_ok   = o;
        tick(1);
        attempt_fail = 1'b0;
        attempt_ok   = 1'b0;
    endtask

    // Scoreboard monitor: pops one expected code per completed handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (code_valid) n_valid++;
            if (prev_valid && code_valid) check("code_out_stable", code_out, prev_code);
            if (code_valid && code_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_capture: got code_out %h, expected no capture", code_out);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("capture_code", code_out, exp_code);
                end
            end
        end
        prev_valid = reset_n & code_valid;
        prev_code  = code_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int base_v;
        int base_hs;
        int n;

        // Reset state
        tick(3);
        check("rst_code_valid", code_valid, 0);
        check("rst_code_out", code_out, 16'h0000);
        check("rst_attempts", attempts, 0);
        check("rst_lockout", lockout, 0);
        reset_n = 1'b1;
        tick(3);

        // Clean press, ready high
        code_ready = 1'b1;
        sw = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        btn_raw = 1'b1;
        wait_valid("clean_press", lat);
        check("clean_latency", lat, 6);
        tick(1);
        check("clean_valid_one_cycle", code_valid, 0);
        check("clean_hs_count", n_hs, 1);
        tick(3);
        btn_raw = 1'b0;
        tick(10);

        // Bouncing press: only the final stable press captures
        base_hs = n_hs;
        base_v  = n_valid;
        sw = 16'h3C5A;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            tick(2);
        end
        check("bounce_no_early_capture", n_valid, base_v);
        exp_q.push_back(16'h3C5A);
        btn_raw = 1'b1;
        wait_valid("bounce_press", lat);
        check("bounce_latency", lat, 6);
        tick(8);
        check("bounce_one_capture", n_hs, base_hs + 1);
        btn_raw = 1'b0;
        tick(10);

        // Back-pressure: code held while ready is low
        code_ready = 1'b0;
        sw = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        btn_raw = 1'b1;
        wait_valid("hold_press", lat);
        sw = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_valid", code_valid, 1);
            check("hold_code", code_out, 16'hA5C3);
        end
        base_hs = n_hs;
        code_ready = 1'b1;
        tick(1);
        check("hold_released_valid", code_valid, 0);
        check("hold_hs_count", n_hs, base_hs + 1);
        tick(6);
        btn_raw = 1'b0;
        tick(10);

        // Three failures then lockout
        pulse(1'b1, 1'b0);
        check("fail1_attempts", attempts, 1);
        pulse(1'b1, 1'b0);
        check("fail2_attempts", attempts, 2);
        pulse(1'b1, 1'b0);
        check("fail3_attempts", attempts, 3);
        tick(1);
        check("lockout_asserted", lockout, 1);
        base_v = n_valid;
        btn_raw = 1'b1;
        n = 1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (lockout) n++;
            else break;
        end
        check("lockout_duration", n, 20);
        check("lockout_attempts_cleared", attempts, 0);
        tick(10);
        check("lockout_no_capture", n_valid, base_v);
        btn_raw = 1'b0;
        tick(10);

        // Simultaneous fail and ok at attempts=2
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("tie_pre_attempts", attempts, 2);
        pulse(1'b1, 1'b1);
        check("tie_attempts", attempts, 0);
        tick(1);
        check("tie_no_lockout", lockout, 0);

        // Reset mid-handshake with the button held
        code_ready = 1'b0;
        sw = 16'hBEEF;
        btn_raw = 1'b1;
        wait_valid("reset_press", lat);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("reset_valid", code_valid, 0);
        check("reset_code_out", code_out, 16'h0000);
        base_v = n_valid;
        tick(20);
        check("reset_held_no_capture", n_valid, base_v);
        code_ready = 1'b1;
        btn_raw = 1'b0;
        tick(10);
        sw = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        btn_raw = 1'b1;
        wait_valid("repress_after_reset", lat);
        check("repress_latency", lat, 6);
        tick(4);
        btn_raw = 1'b0;
        tick(10);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
